// File: rtl/counter_step_ctrl.sv
// counter_step_ctrl: merges two asynchronous step buttons and an auto-tick
// prescaler into single-cycle inc pulses with a direction select, and holds
// the mode bits (max_val, max_en, carry_en) for one 4-bit counter.
module counter_step_ctrl #(
  parameter int         GAP        = 2,
  parameter logic [7:0] RST_PERIOD = 8'd99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       cfg_we,
  input  logic       cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic       inc,
  output logic       up_down_sel,
  output logic       carry_en,
  output logic       max_en,
  output logic [3:0] max_val,
  output logic       busy,
  output logic       ovf
);

  // Hold counter width; GAP of 0 or 1 still gets a 1-bit counter.
  localparam int HW = (GAP < 2) ? 1 : $clog2(GAP);
  localparam logic [HW-1:0] HOLD_LOAD = (GAP > 0) ? HW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
  logic            dir_reg, dir_next;

  logic [3:0]      max_val_reg;
  logic            max_en_reg, carry_en_reg, auto_en_reg, auto_dir_reg;
  logic [7:0]      period_reg;
  logic [7:0]      presc_cnt_reg;
  logic            pend_auto_reg;
  logic            ovf_reg;

  // Button request path, index 0 = up, index 1 = down.
  logic [1:0]      btn_in;
  logic [1:0]      btn_rise;
  logic [1:0]      pend_btn;
  logic [1:0]      clr_btn;
  logic [1:0]      drop_btn;

  logic            tick;
  logic            clr_auto;
  logic            drop_auto;
  logic            arb_free;
  logic            mode_wr;
  logic            period_wr;

  assign btn_in    = {btn_dn, btn_up};
  assign mode_wr   = cfg_we & ~cfg_addr;
  assign period_wr = cfg_we & cfg_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic sync1_reg, sync2_reg, edge_reg, pend_reg;

      // Two-flop synchroniser followed by an edge-detect flop.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          edge_reg  <= 1'b0;
        end else begin
          sync1_reg <= btn_in[gi];
          sync2_reg <= sync1_reg;
          edge_reg  <= sync2_reg;
        end
      end

      assign btn_rise[gi] = sync2_reg & ~edge_reg;
      // An edge landing on a flag that is being served re-arms it instead of dropping.
      assign drop_btn[gi] = btn_rise[gi] & pend_reg & ~clr_btn[gi];
      assign pend_btn[gi] = pend_reg;

      // Pending request flag: set by a rising edge, cleared when served.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pend_reg <= 1'b0;
        end else begin
          pend_reg <= btn_rise[gi] | (pend_reg & ~clr_btn[gi]);
        end
      end
    end
  endgenerate

  assign tick      = auto_en_reg & (presc_cnt_reg == period_reg);
  assign drop_auto = tick & pend_auto_reg & ~clr_auto;

  // Prescaler count; a period write does not restart the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_reg <= 8'd0;
    end else if (!auto_en_reg || tick) begin
      presc_cnt_reg <= 8'd0;
    end else begin
      presc_cnt_reg <= presc_cnt_reg + 8'd1;
    end
  end

  // Auto-tick pending flag, forced clear while auto mode is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_auto_reg <= 1'b0;
    end else if (!auto_en_reg) begin
      pend_auto_reg <= 1'b0;
    end else begin
      pend_auto_reg <= tick | (pend_auto_reg & ~clr_auto);
    end
  end

  // Mode and period registers, writable in any FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_val_reg  <= 4'd0;
      max_en_reg   <= 1'b0;
      carry_en_reg <= 1'b0;
      auto_en_reg  <= 1'b0;
      auto_dir_reg <= 1'b0;
      period_reg   <= RST_PERIOD;
    end else begin
      if (mode_wr) begin
        max_val_reg  <= cfg_wdata[3:0];
        max_en_reg   <= cfg_wdata[4];
        carry_en_reg <= cfg_wdata[5];
        auto_en_reg  <= cfg_wdata[6];
        auto_dir_reg <= cfg_wdata[7];
      end
      if (period_wr) begin
        period_reg <= cfg_wdata;
      end
    end
  end

  // Sticky drop flag; a mode write clears it and wins over a same-cycle drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (mode_wr) begin
      ovf_reg <= 1'b0;
    end else if ((|drop_btn) || drop_auto) begin
      ovf_reg <= 1'b1;
    end
  end

  // FSM state, hold counter and registered direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
      dir_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      dir_reg      <= dir_next;
    end
  end

  // Next state and arbitration. The last cycle of the gap arbitrates like
  // IDLE so back-to-back requests are issued every GAP+1 cycles.
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    dir_next      = dir_reg;
    clr_btn       = 2'b00;
    clr_auto      = 1'b0;
    arb_free      = 1'b0;

    case (state_reg)
      IDLE: begin
        arb_free = 1'b1;
      end
      ISSUE: begin
        if (GAP > 0) begin
          state_next    = HOLD;
          hold_cnt_next = HOLD_LOAD;
        end else begin
          state_next = IDLE;
          arb_free   = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt_reg == '0) begin
          state_next = IDLE;
          arb_free   = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt_reg - HW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (arb_free) begin
      if (pend_btn[0] && pend_btn[1]) begin
        // Opposing requests cancel each other.
        clr_btn = 2'b11;
      end else if (pend_btn[0]) begin
        clr_btn[0] = 1'b1;
        dir_next   = 1'b0;
        state_next = ISSUE;
      end else if (pend_btn[1]) begin
        clr_btn[1] = 1'b1;
        dir_next   = 1'b1;
        state_next = ISSUE;
      end else if (pend_auto_reg && auto_en_reg) begin
        clr_auto   = 1'b1;
        dir_next   = auto_dir_reg;
        state_next = ISSUE;
      end
    end
  end

  assign inc         = (state_reg == ISSUE);
  assign busy        = (state_reg != IDLE);
  assign up_down_sel = dir_reg;
  assign max_val     = max_val_reg;
  assign max_en      = max_en_reg;
  assign carry_en    = carry_en_reg;
  assign ovf         = ovf_reg;

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Bench for counter_step_ctrl: directed scenarios, every output checked each
// cycle against a timestamp-level reference model, plus literal expectations.
`timescale 1ns/1ps
module tb_counter_step_ctrl;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic       cfg_we = 1'b0;
  logic       cfg_addr = 1'b0;
  logic [7:0] cfg_wdata = 8'd0;
  logic       inc, up_down_sel, carry_en, max_en, busy, ovf;
  logic [3:0] max_val;

  int checks = 0;
  int errors = 0;

  counter_step_ctrl #(.GAP(GAP), .RST_PERIOD(8'd99)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up     (btn_up),
    .btn_dn     (btn_dn),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .inc        (inc),
    .up_down_sel(up_down_sel),
    .carry_en   (carry_en),
    .max_en     (max_en),
    .max_val    (max_val),
    .busy       (busy),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (edge-indexed timestamps) ----------------
  int       edge_n = 0;        // index of the last clock edge out of reset
  int       m_last_issue;      // edge after which the last inc was high
  bit       m_dir, m_ovf, m_pu, m_pd, m_pa;
  bit [2:0] m_hu, m_hd;        // button samples at edges n-1, n-2, n-3
  int       m_cnt, m_period;
  int       m_max_val;
  bit       m_max_en, m_carry_en, m_auto_en, m_auto_dir;

  task automatic model_reset();
    m_last_issue = -1000;
    m_dir = 0; m_ovf = 0; m_pu = 0; m_pd = 0; m_pa = 0;
    m_hu = 3'b000; m_hd = 3'b000;
    m_cnt = 0; m_period = 99;
    m_max_val = 0; m_max_en = 0; m_carry_en = 0; m_auto_en = 0; m_auto_dir = 0;
  endtask

  task automatic model_edge();
    bit ev_u, ev_d, tick, clr_u, clr_d, clr_a, drop;
    edge_n = edge_n + 1;
    // a level first sampled at edge n-2 becomes a request at edge n
    ev_u = m_hu[1] && !m_hu[2];
    ev_d = m_hd[1] && !m_hd[2];
    clr_u = 0; clr_d = 0; clr_a = 0;
    // a new inc may start GAP+1 edges after the previous one
    if (edge_n - m_last_issue >= GAP + 1) begin
      if (m_pu && m_pd) begin
        clr_u = 1; clr_d = 1;
      end else if (m_pu) begin
        clr_u = 1; m_last_issue = edge_n; m_dir = 0;
      end else if (m_pd) begin
        clr_d = 1; m_last_issue = edge_n; m_dir = 1;
      end else if (m_pa && m_auto_en) begin
        clr_a = 1; m_last_issue = edge_n; m_dir = m_auto_dir;
      end
    end
    tick = 0;
    if (m_auto_en) begin
      if (m_cnt == m_period) begin
        tick = 1; m_cnt = 0;
      end else begin
        m_cnt = (m_cnt + 1) % 256;
      end
    end else begin
      m_cnt = 0;
    end
    drop = (ev_u && m_pu && !clr_u) || (ev_d && m_pd && !clr_d) || (tick && m_pa && !clr_a);
    m_pu = ev_u || (m_pu && !clr_u);
    m_pd = ev_d || (m_pd && !clr_d);
    m_pa = m_auto_en && (tick || (m_pa && !clr_a));
    m_hu = {m_hu[1:0], btn_up};
    m_hd = {m_hd[1:0], btn_dn};
    if (cfg_we && !cfg_addr) begin
      m_ovf      = 0;
      m_max_val  = int'(cfg_wdata[3:0]);
      m_max_en   = cfg_wdata[4];
      m_carry_en = cfg_wdata[5];
      m_auto_en  = cfg_wdata[6];
      m_auto_dir = cfg_wdata[7];
    end else if (drop) begin
      m_ovf = 1;
    end
    if (cfg_we && cfg_addr) m_period = int'(cfg_wdata);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  int inc_q[$];
  int dir_q[$];
  int busy_cnt = 0;

  // Compare process: every cycle out of reset, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("inc",         int'(inc),         int'(m_last_issue == edge_n));
        chk("up_down_sel", int'(up_down_sel), int'(m_dir));
        chk("busy",        int'(busy),        int'(edge_n - m_last_issue <= GAP));
        chk("ovf",         int'(ovf),         int'(m_ovf));
        chk("max_val",     int'(max_val),     m_max_val);
        chk("max_en",      int'(max_en),      int'(m_max_en));
        chk("carry_en",    int'(carry_en),    int'(m_carry_en));
        if (inc) begin
          inc_q.push_back(edge_n);
          dir_q.push_back(int'(up_down_sel));
          $display("inc pulse at edge %0d dir %0d", edge_n, up_down_sel);
        end
        if (busy) busy_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers (drive 1ns after falling edge) ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    inc_q.delete();
    dir_q.delete();
    busy_cnt = 0;
  endtask

  task automatic cfg_write(input logic a, input logic [7:0] d, output int wr_edge);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    wr_edge = edge_n + 1;
    step(1);
    cfg_we = 1'b0;
    $display("cfg write addr %0d data 0x%02h at edge %0d", a, d, wr_edge);
  endtask

  task automatic wait_inc(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1);
      if (inc) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: inc seen 0, required 1 within %0d cycles", name, budget);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int k, e1, we, n_up, up_edge;

    #2 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    chk("rst_inc", int'(inc), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_max_val", int'(max_val), 0);
    chk("rst_dir", int'(up_down_sel), 0);
    step(2);

    // 1: held up button -> one pulse, 3 edges after first sample, busy 3 cycles
    clear_log();
    btn_up = 1'b1; k = edge_n + 1;
    step(5);
    btn_up = 1'b0;
    step(10);
    chk("t1_inc_count", inc_q.size(), 1);
    if (inc_q.size() > 0) begin
      chk("t1_latency", inc_q[0] - k, 3);
      chk("t1_dir", dir_q[0], 0);
    end
    chk("t1_busy_cycles", busy_cnt, 3);

    // 2: period 3, auto down -> first pulse 5 edges after enable, then every 4
    cfg_write(1'b1, 8'd3, we);
    clear_log();
    cfg_write(1'b0, 8'hC0, e1);
    step(20);
    chk("t2_inc_count", inc_q.size(), 4);
    if (inc_q.size() > 0) chk("t2_first", inc_q[0] - e1, 5);
    for (int i = 1; i < inc_q.size(); i++) chk("t2_spacing", inc_q[i] - inc_q[i-1], 4);
    foreach (dir_q[i]) chk("t2_dir", dir_q[i], 1);
    cfg_write(1'b0, 8'h00, we);
    clear_log();
    step(20);
    chk("t2_auto_off_incs", inc_q.size(), 0);

    // 3: both buttons rise together -> cancelled, no pulse, no ovf
    clear_log();
    btn_up = 1'b1; btn_dn = 1'b1;
    step(4);
    btn_up = 1'b0; btn_dn = 1'b0;
    step(8);
    chk("t3_inc_count", inc_q.size(), 0);
    chk("t3_busy_cycles", busy_cnt, 0);
    chk("t3_ovf", int'(ovf), 0);

    // 4: period 0, auto down, up edge -> up wins once, pulses every 3, ovf set
    cfg_write(1'b1, 8'd0, we);
    cfg_write(1'b0, 8'hC0, we);
    step(6);
    clear_log();
    btn_up = 1'b1; k = edge_n + 1;
    step(3);
    btn_up = 1'b0;
    step(12);
    n_up = 0; up_edge = -1;
    foreach (dir_q[i]) if (dir_q[i] == 0) begin n_up++; up_edge = inc_q[i]; end
    chk("t4_up_pulses", n_up, 1);
    chk("t4_up_latency_in_range", int'(up_edge - k >= 3 && up_edge - k <= 5), 1);
    for (int i = 1; i < inc_q.size(); i++) chk("t4_spacing", inc_q[i] - inc_q[i-1], 3);
    chk("t4_ovf_set", int'(ovf), 1);
    cfg_write(1'b0, 8'h00, we);
    chk("t4_ovf_cleared", int'(ovf), 0);
    step(6);

    // 5: mode write during ISSUE takes effect at the next edge
    btn_up = 1'b1;
    wait_inc("t5_wait_inc", 20);
    cfg_write(1'b0, 8'h29, we);
    chk("t5_max_val", int'(max_val), 9);
    chk("t5_max_en", int'(max_en), 0);
    chk("t5_carry_en", int'(carry_en), 1);
    chk("t5_busy_in_hold", int'(busy), 1);
    btn_up = 1'b0;
    step(6);

    // 6: reset asserted mid-ISSUE clears outputs with no clock edge
    btn_dn = 1'b1;
    wait_inc("t6_wait_inc", 20);
    chk("t6_dir_before_reset", int'(up_down_sel), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_inc", int'(inc), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_dir", int'(up_down_sel), 0);
    chk("t6_max_val", int'(max_val), 0);
    chk("t6_carry_en", int'(carry_en), 0);
    chk("t6_max_en", int'(max_en), 0);
    chk("t6_ovf", int'(ovf), 0);
    btn_dn = 1'b0;
    step(2);
    rst_n = 1'b1;
    clear_log();
    step(10);
    chk("t6_incs_after_reset", inc_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_step_ctrl.md
Name: counter_step_ctrl

Overview:
Step scheduler and configuration holder for one 4-bit counter instance. It merges two manual step requests (up and down buttons, asynchronous) with an internal auto-tick prescaler into single-cycle `inc` pulses plus a direction select. It also holds the counter mode bits (`max_en`, `max_val`, `carry_en`) written over a small config port. It sits between the pad/config logic and the counter datapath.

Parameters:
GAP, 2, idle cycles forced after every issued `inc` pulse (0 allowed).
RST_PERIOD, 8'd99, reset value of the prescaler period register.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_up  in  1  asynchronous level; rising edge = one up-step request
btn_dn  in  1  asynchronous level; rising edge = one down-step request
cfg_we  in  1  config write strobe, one cycle
cfg_addr  in  1  0 = mode register, 1 = period register
cfg_wdata  in  8  write data
inc  out  1  single-cycle step pulse to counter
up_down_sel  out  1  direction to counter: 0 = up, 1 = down; valid whenever `inc` = 1
carry_en  out  1  mode bit to counter
max_en  out  1  mode bit to counter
max_val  out  4  max value to counter
busy  out  1  1 while FSM is not in IDLE
ovf  out  1  sticky dropped-request flag

Behaviour:
- Reset (asynchronous, `rst_n` = 0):
  - All outputs 0.
  - All pending flags, sync flops and prescaler count cleared.
  - Period register = RST_PERIOD.
  - FSM goes to IDLE; `inc` drops immediately, even mid-pulse.
- Mode register (addr 0), written at the clk edge where `cfg_we` = 1:
  - [3:0] → `max_val`
  - [4] → `max_en`
  - [5] → `carry_en`
  - [6] → `auto_en`
  - [7] → `auto_dir` (1 = down)
  - Outputs change at that edge in any FSM state.
  - A write to addr 0 also clears `ovf`.
- Period register (addr 1): 8 bits, written at the same edge; the write does not reset the prescaler count.
- Button input path:
  - 2-flop synchroniser followed by an edge flop; a rising edge sets `pend_up` or `pend_dn`.
  - Latency: a level first sampled high at edge k sets the pending flag at edge k+2. From IDLE, `inc` is high between edges k+3 and k+4.
  - Holding the button produces exactly one request.
- Prescaler:
  - 8-bit count runs only while `auto_en` = 1.
  - When count == period: count → 0 and `pend_auto` is set. Otherwise count increments.
  - Period 0 → a tick every cycle.
  - `auto_en` = 0 → count and `pend_auto` held cleared.
- Overflow: a new edge or tick that arrives while its own pending flag is already set is dropped and sets `ovf`.
- FSM states IDLE, ISSUE, HOLD:
  - IDLE, arbitration in priority order:
    - `pend_up` and `pend_dn` both set → clear both, no pulse, stay in IDLE (`pend_auto` is served next cycle).
    - else `pend_up` → `up_down_sel` = 0, go to ISSUE.
    - else `pend_dn` → `up_down_sel` = 1, go to ISSUE.
    - else `pend_auto` → `up_down_sel` = `auto_dir`, go to ISSUE.
    - The served pending flag clears on the transition edge.
  - ISSUE: `inc` = 1 for exactly one cycle. Next state is HOLD if GAP > 0, else IDLE.
  - HOLD: wait GAP cycles, then go to IDLE.
  - Requests arriving in ISSUE or HOLD stay pending; nothing is lost unless it hits the overflow rule.
- `up_down_sel` is registered and holds its last value between pulses.
- A pending flag set in the same cycle it is served is re-set, not lost, when the new event is a distinct edge.
- `busy` = 1 in ISSUE and HOLD.
- Maximum step rate is one `inc` every GAP+1 cycles.

Test Plan:
1. Reset, then pulse `btn_up` for 5 cycles → exactly one `inc`, high during cycle 3 after first sample, `up_down_sel` = 0; `busy` high for 1+GAP = 3 cycles.
2. Write addr 1 = 3, addr 0 = 8'hC0 (auto on, down) → `inc` every 4 cycles with `up_down_sel` = 1; `auto_en` cleared → no further pulses.
3. `btn_up` and `btn_dn` rising in the same cycle while IDLE → no `inc`, `ovf` = 0.
4. Period 0 with auto on, then `btn_up` edge → up pulse served before the pending auto tick; auto pulses continue every 3 cycles; `ovf` = 1 because ticks are dropped during HOLD; write addr 0 → `ovf` = 0.
5. Write addr 0 = 8'h29 → `max_val` = 9, `max_en` = 0, `carry_en` = 1 on the next edge, even while in ISSUE.
6. Deassert `rst_n` during ISSUE → `inc`, `busy` and mode outputs go to 0 immediately, with no clock edge needed.
